// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier operand sequencer slice.
package mult_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_WAIT,
        ST_DONE,
        ST_ERR
    } seq_state_e;

endpackage

// File: rtl/mult_op_fifo.sv
// Small synchronous FIFO holding operand pairs for the sequencer.
module mult_op_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mult_operand_sequencer.sv
// Feeds buffered (A,B) pairs onto the repeated-addition core's shared data bus.
module mult_operand_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] mul_data,
    output logic             mul_start,
    input  logic             mul_done,
    output logic             op_done,
    output logic             err_timeout,
    output logic             busy,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    seq_state_e         state;
    seq_state_e         state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [TW-1:0]      timer;
    logic               ready_en;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               fifo_push;
    logic [2*WIDTH-1:0] fifo_rdata;

    // Producer sees ready only once out of reset and while there is room.
    assign in_ready  = ready_en & ~fifo_full;
    assign fifo_push = in_valid & in_ready;
    assign busy      = (state != ST_IDLE);

    mult_op_fifo #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({in_a, in_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; a still-high done in IDLE blocks a false issue.
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !mul_done && !err_timeout) begin
                    state_next = ST_START;
                    fifo_pop   = 1'b1;
                end
            end
            ST_START:  state_next = ST_LOAD_A;
            ST_LOAD_A: state_next = ST_LOAD_B;
            ST_LOAD_B: state_next = ST_WAIT;
            ST_WAIT: begin
                if (mul_done)             state_next = ST_DONE;
                else if (timer == T_LAST) state_next = ST_ERR;
            end
            ST_DONE:   state_next = ST_IDLE;
            ST_ERR:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Bus and handshake outputs are decoded from the current state.
    always_comb begin
        mul_data  = '0;
        mul_start = 1'b0;
        op_done   = 1'b0;
        case (state)
            ST_START: begin
                mul_start = 1'b1;
                mul_data  = a_reg;
            end
            ST_LOAD_A: mul_data = a_reg;
            ST_LOAD_B: mul_data = b_reg;
            ST_WAIT:   mul_data = b_reg;
            ST_DONE:   op_done  = 1'b1;
            default:   mul_data = '0;
        endcase
    end

    // Operand latch, wait timer, sticky error, issue counter and ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            timer       <= '0;
            err_timeout <= 1'b0;
            issued_cnt  <= '0;
            ready_en    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (fifo_pop) begin
                a_reg <= fifo_rdata[2*WIDTH-1:WIDTH];
                b_reg <= fifo_rdata[WIDTH-1:0];
            end
            if (state != ST_WAIT) timer <= '0;
            else                  timer <= timer + 1'b1;
            if (state == ST_WAIT && state_next == ST_ERR) err_timeout <= 1'b1;
            if (state == ST_LOAD_B) issued_cnt <= issued_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for the operand sequencer with a simple behavioural core.
module tb_mult_operand_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] mul_data;
    logic        mul_start;
    logic        mul_done;
    logic        op_done;
    logic        err_timeout;
    logic        busy;
    logic [7:0]  issued_cnt;

    int testCount = 0;
    int failCount = 0;

    logic forceDone = 1'b0;
    logic coreEn    = 1'b1;
    int   coreDelay = 3;
    logic coreRun;
    logic coreDone;
    int   coreCnt;

    logic [15:0] obsA[$];
    logic [15:0] obsB[$];
    int          age = 0;
    int          opDoneCnt = 0;

    typedef struct {
        logic        valid;
        logic [15:0] a;
        logic [15:0] b;
        logic        start;
        logic [15:0] data;
        logic        opd;
        logic        busy;
        logic [7:0]  issued;
    } vec_t;

    vec_t vecs[8];

    mult_operand_sequencer #(
        .WIDTH   (16),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_data    (mul_data),
        .mul_start   (mul_start),
        .mul_done    (mul_done),
        .op_done     (op_done),
        .err_timeout (err_timeout),
        .busy        (busy),
        .issued_cnt  (issued_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Core model: raises done coreDelay cycles after seeing start, drops it once op_done is seen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coreRun  <= 1'b0;
            coreDone <= 1'b0;
            coreCnt  <= 0;
        end else begin
            if (mul_start) begin
                coreRun <= 1'b1;
                coreCnt <= 0;
            end else if (coreRun) begin
                if (coreCnt + 1 >= coreDelay) begin
                    coreDone <= 1'b1;
                    coreRun  <= 1'b0;
                end
                coreCnt <= coreCnt + 1;
            end
            if (op_done) coreDone <= 1'b0;
        end
    end

    assign mul_done = forceDone | (coreEn & coreDone);

    // Bus monitor: records A at start, B two cycles later, and counts op_done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            age       = 0;
            opDoneCnt = 0;
        end else begin
            if (op_done) opDoneCnt = opDoneCnt + 1;
            if (mul_start) begin
                obsA.push_back(mul_data);
                age = 1;
            end else if (age == 1) begin
                age = 2;
            end else if (age == 2) begin
                obsB.push_back(mul_data);
                age = 0;
            end
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Push one pair; called at a negedge, returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        int guard = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("push_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitIssued(input logic [7:0] target, input int limit, input string name);
        int n = 0;
        while (!(issued_cnt == target && !busy) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {24'd0, issued_cnt}, {24'd0, target});
    endtask

    initial begin
        int s;
        int n;
        int bad;

        // Single-op cycle table: inputs per cycle, outputs seen after the following edge.
        vecs[0] = '{1'b1, 16'd7, 16'd4, 1'b0, 16'd0, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{1'b0, 16'd0, 16'd0, 1'b1, 16'd7, 1'b0, 1'b1, 8'd0};
        vecs[2] = '{1'b0, 16'd0, 16'd0, 1'b0, 16'd7, 1'b0, 1'b1, 8'd0};
        vecs[3] = '{1'b0, 16'd0, 16'd0, 1'b0, 16'd4, 1'b0, 1'b1, 8'd0};
        vecs[4] = '{1'b0, 16'd0, 16'd0, 1'b0, 16'd4, 1'b0, 1'b1, 8'd1};
        vecs[5] = '{1'b0, 16'd0, 16'd0, 1'b0, 16'd4, 1'b0, 1'b1, 8'd1};
        vecs[6] = '{1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b1, 1'b1, 8'd1};
        vecs[7] = '{1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0, 8'd1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;

        // Test 1: reset values, then reset in the middle of LOAD_A.
        #1;
        checkOutput("t1_rst_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("t1_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t1_rst_issued", {24'd0, issued_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t1_ready_after_release", {31'd0, in_ready}, 32'd1);
        forceDone = 1'b1;
        applyStimulus(16'd5, 16'd3);
        applyStimulus(16'd6, 16'd6);
        forceDone = 1'b0;
        @(negedge clk);
        checkOutput("t1_start", {31'd0, mul_start}, 32'd1);
        checkOutput("t1_start_data", {16'd0, mul_data}, 32'd5);
        @(negedge clk);
        checkOutput("t1_loada_data", {16'd0, mul_data}, 32'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("t1_abort_data", {16'd0, mul_data}, 32'd0);
        checkOutput("t1_abort_start", {31'd0, mul_start}, 32'd0);
        checkOutput("t1_abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("t1_abort_opdone", {31'd0, op_done}, 32'd0);
        checkOutput("t1_abort_err", {31'd0, err_timeout}, 32'd0);
        checkOutput("t1_abort_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s = 0;
        repeat (8) begin
            @(negedge clk);
            if (mul_start) s++;
        end
        checkOutput("t1_fifo_flushed", s, 32'd0);
        checkOutput("t1_ready_idle", {31'd0, in_ready}, 32'd1);

        // Test 2: single operation, cycle by cycle from the table.
        coreDelay = 3;
        for (int r = 0; r < 8; r++) begin
            in_valid = vecs[r].valid;
            in_a     = vecs[r].a;
            in_b     = vecs[r].b;
            @(negedge clk);
            checkOutput($sformatf("t2_r%0d_start", r), {31'd0, mul_start}, {31'd0, vecs[r].start});
            checkOutput($sformatf("t2_r%0d_data", r), {16'd0, mul_data}, {16'd0, vecs[r].data});
            checkOutput($sformatf("t2_r%0d_opdone", r), {31'd0, op_done}, {31'd0, vecs[r].opd});
            checkOutput($sformatf("t2_r%0d_busy", r), {31'd0, busy}, {31'd0, vecs[r].busy});
            checkOutput($sformatf("t2_r%0d_issued", r), {24'd0, issued_cnt}, {24'd0, vecs[r].issued});
        end
        in_valid = 1'b0;

        // Test 3: fill the FIFO while the core still reports done, then drain in order.
        obsA.delete();
        obsB.delete();
        forceDone = 1'b1;
        applyStimulus(16'd11, 16'd2);
        applyStimulus(16'd12, 16'd3);
        applyStimulus(16'd13, 16'd4);
        applyStimulus(16'd14, 16'd5);
        checkOutput("t3_full_ready", {31'd0, in_ready}, 32'd0);
        forceDone = 1'b0;
        applyStimulus(16'd15, 16'd6);
        waitIssued(8'd6, 300, "t3_issued");
        checkOutput("t3_popcount", obsA.size(), 32'd5);
        for (int k = 0; k < 5 && k < obsA.size() && k < obsB.size(); k++) begin
            checkOutput($sformatf("t3_a%0d", k), {16'd0, obsA[k]}, 11 + k);
            checkOutput($sformatf("t3_b%0d", k), {16'd0, obsB[k]}, 2 + k);
        end

        // Test 4: sticky done holds the FSM in IDLE until it drops.
        forceDone = 1'b1;
        applyStimulus(16'd2, 16'd2);
        s = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) s++;
        end
        checkOutput("t4_held_idle", s, 32'd0);
        forceDone = 1'b0;
        @(negedge clk);
        checkOutput("t4_start", {31'd0, mul_start}, 32'd1);
        checkOutput("t4_start_data", {16'd0, mul_data}, 32'd2);
        waitIssued(8'd7, 100, "t4_issued");

        // Test 5: core never answers, so the wait timer must expire after 16 WAIT cycles.
        coreEn = 1'b0;
        applyStimulus(16'd9, 16'd9);
        n = 0;
        while (issued_cnt != 8'd8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_issued", {24'd0, issued_cnt}, 32'd8);
        repeat (15) @(negedge clk);
        checkOutput("t5_err_early", {31'd0, err_timeout}, 32'd0);
        checkOutput("t5_still_wait", {16'd0, mul_data}, 32'd9);
        @(negedge clk);
        checkOutput("t5_err_set", {31'd0, err_timeout}, 32'd1);
        checkOutput("t5_err_busy", {31'd0, busy}, 32'd1);
        applyStimulus(16'd1, 16'd1);
        applyStimulus(16'd3, 16'd3);
        s = 0;
        repeat (30) begin
            @(negedge clk);
            if (mul_start) s++;
        end
        checkOutput("t5_no_start", s, 32'd0);
        checkOutput("t5_err_sticky", {31'd0, err_timeout}, 32'd1);
        checkOutput("t5_idle", {31'd0, busy}, 32'd0);

        // Test 6: 256 quick operations wrap the issue counter back to zero.
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        coreEn    = 1'b1;
        coreDelay = 1;
        obsA.delete();
        obsB.delete();
        @(negedge clk);
        checkOutput("t6_err_cleared", {31'd0, err_timeout}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(16'(i), 16'd0);
        end
        n = 0;
        while ((opDoneCnt < 256 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_opdone_count", opDoneCnt, 32'd256);
        checkOutput("t6_issued_wrap", {24'd0, issued_cnt}, 32'd0);
        bad = 0;
        for (int i = 0; i < obsA.size(); i++) begin
            if (obsA[i] != 16'(i)) bad++;
        end
        checkOutput("t6_order", bad, 32'd0);
        checkOutput("t6_issue_count", obsA.size(), 32'd256);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
